// File: rtl/counter_bus_arbiter.sv
// rtl/counter_bus_arbiter.sv - arbitrates load/read access to a bank of counters on a shared bus
// Optional CNT_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module counter_bus_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH-1:0]     req_load,
  input  logic [8*NUM_CH-1:0]   req_data,
  output logic [NUM_CH-1:0]     req_ready,
  input  logic [NUM_CH-1:0]     count_req,
  output logic [NUM_CH-1:0]     cnt_en,
  output logic [NUM_CH-1:0]     cnt_load,
  output logic [7:0]            cnt_data,
  output logic [NUM_CH-1:0]     cnt_oe,
  input  logic [7:0]            bus_in,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic [2:0]            rd_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_SAMPLE,
    S_TURN
  } state_t;

  localparam logic [1:0] GAP_LAST = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  state_t      state_q, state_d;
  logic [2:0]  g_q, g_d;
  logic [7:0]  cnt_data_q, cnt_data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [2:0]  rd_id_q, rd_id_d;
  logic        rd_valid_q, rd_valid_d;
  logic [1:0]  gap_q, gap_d;
  logic [2:0]  win;
  logic        any_req;

`ifdef CNT_ARB_FIXED_PRI_EN
  always_comb begin
    win     = '0;
    any_req = |req_valid;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) win = 3'(i);
    end
  end
`else
  logic [2:0]  rr_q, rr_d;
  logic        arb_found;

  // Search starts at the pointer and wraps; first hit wins.
  always_comb begin
    win       = '0;
    arb_found = 1'b0;
    any_req   = |req_valid;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!arb_found && req_valid[(int'(rr_q) + k) % NUM_CH]) begin
        win       = 3'((int'(rr_q) + k) % NUM_CH);
        arb_found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    cnt_data_d = cnt_data_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    rd_valid_d = 1'b0;
    gap_d      = gap_q;
`ifndef CNT_ARB_FIXED_PRI_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          g_d = win;
`ifndef CNT_ARB_FIXED_PRI_EN
          rr_d = (win == 3'(NUM_CH - 1)) ? 3'd0 : win + 3'd1;
`endif
          // Load data is captured at grant so cnt_data is stable throughout LOAD.
          if (req_load[win]) begin
            state_d    = S_LOAD;
            cnt_data_d = req_data[8*int'(win) +: 8];
          end else begin
            state_d = S_DRIVE;
          end
        end
      end
      S_LOAD:  state_d = S_IDLE;
      S_DRIVE: state_d = S_SAMPLE;
      S_SAMPLE: begin
        rd_data_d  = bus_in;
        rd_id_d    = g_q;
        rd_valid_d = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_d = S_TURN;
          gap_d   = GAP_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        if (gap_q == 2'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      cnt_data_q <= '0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      rd_valid_q <= 1'b0;
      gap_q      <= '0;
`ifndef CNT_ARB_FIXED_PRI_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      cnt_data_q <= cnt_data_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      rd_valid_q <= rd_valid_d;
      gap_q      <= gap_d;
`ifndef CNT_ARB_FIXED_PRI_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // Strobes decode only registered state, keeping oe one-hot or zero.
  logic [NUM_CH-1:0] g_oh;
  assign g_oh      = {{(NUM_CH-1){1'b0}}, 1'b1} << g_q;
  assign cnt_load  = (state_q == S_LOAD) ? g_oh : '0;
  assign cnt_oe    = (state_q == S_DRIVE || state_q == S_SAMPLE) ? g_oh : '0;
  assign req_ready = (state_q == S_LOAD || state_q == S_SAMPLE) ? g_oh : '0;
  assign cnt_en    = count_req & ~cnt_oe;
  assign cnt_data  = cnt_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_id     = rd_id_q;

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// tb/tb_counter_bus_arbiter.sv - randomized bench for counter_bus_arbiter against a transaction-level model
module tb_counter_bus_arbiter;
  localparam int N   = 4;
  localparam int GAP = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid, req_load, req_ready, count_req, cnt_en, cnt_load, cnt_oe;
  logic [8*N-1:0]   req_data;
  logic [7:0]       cnt_data, bus_in, rd_data;
  logic             rd_valid;
  logic [2:0]       rd_id;

  always #5 clk = ~clk;

  counter_bus_arbiter #(.NUM_CH(N), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_load(req_load), .req_data(req_data),
    .req_ready(req_ready), .count_req(count_req), .cnt_en(cnt_en), .cnt_load(cnt_load),
    .cnt_data(cnt_data), .cnt_oe(cnt_oe), .bus_in(bus_in), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_id(rd_id)
  );

  int passed = 0;
  int total  = 0;

  // Transaction model: one op in flight, t = cycles since the grant cycle.
  bit         op_act, op_load, rd_exp;
  int         op_g, op_t, rr_m;
  logic [7:0] ld_data_m, rd_data_m;
  logic [2:0] rd_id_m;
  logic [7:0] ref_cnt [N];

  bit         pend [N];
  bit         pend_load [N];
  logic [7:0] pend_data [N];
  int         mode;
  bit         cr_rand;
  logic [N-1:0] cr_fixed;

  int         owners[$];
  int         zero_run, last_gap, rd_seen;
  logic [7:0] ld_seen, rd_seen_data;
  logic [2:0] rd_seen_id;

  always_comb begin
    bus_in = 8'h00;
    for (int i = 0; i < N; i++) if (cnt_oe[i]) bus_in = ref_cnt[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] oh(int i);
    return N'(1) << i;
  endfunction

  function automatic logic [N-1:0] exp_load();
    return (op_act && op_load && op_t == 1) ? oh(op_g) : '0;
  endfunction

  function automatic logic [N-1:0] exp_oe();
    return (op_act && !op_load && (op_t == 1 || op_t == 2)) ? oh(op_g) : '0;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    return (op_act && ((op_load && op_t == 1) || (!op_load && op_t == 2))) ? oh(op_g) : '0;
  endfunction

  function automatic bit m_idle();
    return !op_act || (op_load ? (op_t >= 2) : (op_t >= 3 + GAP));
  endfunction

  function automatic int pick(logic [N-1:0] v, int rr);
`ifdef CNT_ARB_FIXED_PRI_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
`endif
    return 0;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    op_act = 0; op_load = 0; op_g = 0; op_t = 0; rr_m = 0; rd_exp = 0;
    ld_data_m = 8'h00; rd_data_m = 8'h00; rd_id_m = 3'd0;
  endtask

  // Moves the model across the rising edge that just happened.
  task automatic advance();
    logic [N-1:0] oe_o, ld_o;
    int g;
    oe_o = exp_oe();
    ld_o = exp_load();
    rd_exp = op_act && !op_load && op_t == 2 && rst_n;
    if (rd_exp) begin
      rd_data_m = ref_cnt[op_g];
      rd_id_m   = 3'(op_g);
    end
    for (int i = 0; i < N; i++) begin
      if (ld_o[i])                        ref_cnt[i] = ld_data_m;
      else if (count_req[i] && !oe_o[i])  ref_cnt[i] = ref_cnt[i] + 8'd1;
    end
    if (!rst_n) return;
    if (m_idle()) begin
      if (req_valid != '0) begin
        g = pick(req_valid, rr_m);
        op_act = 1; op_g = g; op_load = req_load[g]; op_t = 1;
        if (op_load) ld_data_m = req_data[8*g +: 8];
        rr_m = (g + 1) % N;
      end else begin
        op_act = 0;
      end
    end else begin
      op_t++;
    end
  endtask

  task automatic check_all();
    check("req_ready", 32'(req_ready), 32'(exp_ready()));
    check("cnt_load",  32'(cnt_load),  32'(exp_load()));
    check("cnt_oe",    32'(cnt_oe),    32'(exp_oe()));
    check("cnt_en",    32'(cnt_en),    32'(count_req & ~exp_oe()));
    check("oe_onehot0", 32'($onehot0(cnt_oe)), 32'd1);
    check("rd_valid",  32'(rd_valid),  32'(rd_exp));
    check("rd_data",   32'(rd_data),   32'(rd_data_m));
    check("rd_id",     32'(rd_id),     32'(rd_id_m));
    check("cnt_data",  32'(cnt_data),  32'(ld_data_m));
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_load[i]  = pend_load[i];
      req_data[8*i +: 8] = pend_data[i];
    end
  endtask

  task automatic drive();
    logic [N-1:0] rdy;
    rdy = exp_ready();
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) pend[i] = 0;
      if (!pend[i]) begin
        if (mode == 1 && $urandom_range(3) == 0) begin
          pend[i] = 1; pend_load[i] = $urandom_range(1) == 1; pend_data[i] = 8'($urandom);
        end else if (mode == 2) begin
          pend[i] = 1; pend_load[i] = 0;
        end
      end
    end
    count_req = cr_rand ? N'($urandom) : cr_fixed;
    apply();
  endtask

  task automatic observe();
    int owner;
    owner = 0;
    for (int i = 0; i < N; i++) if (cnt_oe[i]) owner = i;
    if (cnt_oe == '0) zero_run++;
    else begin
      if (zero_run > 0) begin
        owners.push_back(owner);
        last_gap = zero_run;
      end
      zero_run = 0;
    end
    if (cnt_load[1]) ld_seen = cnt_data;
    if (rd_valid) begin
      rd_seen++; rd_seen_data = rd_data; rd_seen_id = rd_id;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    advance();
    check_all();
    observe();
    drive();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (m_idle() && !any_pend()) return;
      cycle();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rr0, exp_owner;
    bit hit;
    model_reset();
    for (int i = 0; i < N; i++) begin
      ref_cnt[i] = 8'h00; pend[i] = 0; pend_load[i] = 0; pend_data[i] = 8'h00;
    end
    mode = 0; cr_rand = 0; cr_fixed = '0; count_req = '0; zero_run = 0; last_gap = 0;
    rd_seen = 0; ld_seen = 8'h00; rd_seen_data = 8'h00; rd_seen_id = 3'd0;
    apply();
    repeat (3) cycle();
    rst_n = 1'b1;
    cr_rand = 1;
    repeat (10) cycle();

    // load 0xA5 into ch1, then read it back with counting frozen
    cr_rand = 0; cr_fixed = '0;
    pend[1] = 1; pend_load[1] = 1; pend_data[1] = 8'hA5; apply();
    wait_idle();
    check("ld_a5_data", 32'(ld_seen), 32'hA5);
    pend[1] = 1; pend_load[1] = 0; apply();
    rd_seen = 0;
    for (int k = 0; k < 20 && rd_seen == 0; k++) cycle();
    check("rd_a5_seen", 32'(rd_seen), 32'd1);
    check("rd_a5_data", 32'(rd_seen_data), 32'hA5);
    check("rd_a5_id",   32'(rd_seen_id),   32'd1);
    wait_idle();

    // ch2 read while its counter is counting
    cr_fixed = N'(4);
    pend[2] = 1; pend_load[2] = 0; apply();
    wait_idle();
    repeat (3) cycle();

    // continuous reads from everybody
    cr_rand = 1;
    rr0 = rr_m;
    owners.delete();
    mode = 2;
    repeat (30) cycle();
    for (int k = 0; k < 5; k++) begin
`ifdef CNT_ARB_FIXED_PRI_EN
      exp_owner = 0;
`else
      exp_owner = (rr0 + k) % N;
`endif
      check("grant_order", 32'(owners.size() > k ? owners[k] : -1), 32'(exp_owner));
    end

    // reset asserted while a read is in SAMPLE
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      cycle();
      hit = op_act && !op_load && op_t == 2;
    end
    check("sample_reached", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
    owners.delete();
    for (int k = 0; k < 20 && owners.size() == 0; k++) cycle();
    check("post_rst_owner", 32'(owners.size() > 0 ? owners[0] : -1), 32'd0);

    // back-to-back reads ch0 then ch3
    mode = 0;
    wait_idle();
    pend[0] = 1; pend_load[0] = 0; apply();
    cycle();
    pend[3] = 1; pend_load[3] = 0; apply();
    owners.delete();
    wait_idle();
    repeat (2) cycle();
    check("b2b_second", 32'(owners.size() > 0 ? owners[owners.size()-1] : -1), 32'd3);
    check("b2b_gap", 32'(last_gap), 32'(GAP + 1));

    // random traffic
    mode = 1;
    repeat (600) cycle();
    mode = 0;
    wait_idle();
    repeat (5) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
